// File: rtl/pe_acc_drain.sv
// Accumulation-buffer drain: reads a programmed address range, requantizes each lane and
// streams BATCH-wide words out through a credit-protected FIFO. Optional ReLU: PE_DRAIN_RELU_EN.
module pe_acc_drain #(
  parameter  int unsigned BATCH      = 4,
  parameter  int unsigned DATA_W     = 16,
  parameter  int unsigned RES_W      = 32,
  parameter  int unsigned BUF_DEPTH  = 256,
  parameter  int unsigned RD_LAT     = 2,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned ADDR_W     = $clog2(BUF_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W:0]           len,
  input  logic [4:0]                shift,
  input  logic                      relu,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         abuf_rd_addr,
  input  logic [BATCH*RES_W-1:0]    abuf_rd_data,
  output logic [BATCH*DATA_W-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

  localparam logic signed [RES_W:0] SAT_MAX = {{(RES_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [RES_W:0] SAT_MIN = {{(RES_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [ADDR_W-1:0]         r_addr;
  logic [ADDR_W:0]           r_remain;
  logic [4:0]                r_shift;
  logic [RD_LAT-1:0]         r_vld;
  logic                      r_q_vld;
  logic [BATCH*DATA_W-1:0]   r_q_data;
  logic [BATCH*DATA_W-1:0]   w_q_data;
  logic [DATA_W-1:0]         w_lane;
  logic [BATCH*DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr;
  logic [PTR_W-1:0]          r_rd_ptr;
  logic [CNT_W-1:0]          r_count;
  logic [OCC_W-1:0]          w_occ;
  logic                      w_start_go;
  logic                      w_issue;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_pipe_empty;

`ifdef PE_DRAIN_RELU_EN
  logic                      r_relu;
`else
  logic                      w_unused_relu;
  assign w_unused_relu = relu;
`endif

  function automatic logic [ADDR_W-1:0] f_addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(BUF_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Round-half-up then arithmetic shift, carried in RES_W+1 bits, then clamp to DATA_W.
  function automatic logic [DATA_W-1:0] f_quant(input logic [RES_W-1:0] x, input logic [4:0] sh);
    logic signed [RES_W:0] v_ext;
    logic        [RES_W:0] v_rnd;
    logic signed [RES_W:0] v_sum;
    logic signed [RES_W:0] v_t;
    logic        [DATA_W-1:0] v_out;
    v_ext = {x[RES_W-1], x};
    v_rnd = (sh == '0) ? '0 : ((RES_W + 1)'(1) << (sh - 5'd1));
    v_sum = v_ext + $signed(v_rnd);
    v_t   = v_sum >>> sh;
    if (v_t > SAT_MAX)      v_out = SAT_MAX[DATA_W-1:0];
    else if (v_t < SAT_MIN) v_out = SAT_MIN[DATA_W-1:0];
    else                    v_out = v_t[DATA_W-1:0];
    return v_out;
  endfunction

  assign w_pop        = out_valid & out_ready;
  assign w_push       = r_q_vld;
  assign w_pipe_empty = (r_vld == '0) && !r_q_vld;
  assign w_start_go   = (r_state == S_IDLE) && start && (len != '0);

  // The first read goes out in the start cycle itself so the first word lands RD_LAT+2 later.
  assign abuf_rd_addr = ((r_state == S_IDLE) && start) ? base_addr : r_addr;

  // Occupancy counts the pop happening this cycle as freed; an issued read always finds a slot.
  always_comb begin
    w_occ = OCC_W'(r_count) + OCC_W'(r_q_vld);
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      w_occ = w_occ + OCC_W'(r_vld[i]);
    end
    w_occ = w_occ - OCC_W'(w_pop);
  end

  assign w_issue = w_start_go || ((r_state == S_RUN) && (w_occ < OCC_W'(FIFO_DEPTH)));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len == '0)                         w_state_nxt = S_DONE;
          else if (len == (ADDR_W + 1)'(1))      w_state_nxt = S_FLUSH;
          else                                   w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_issue && (r_remain == (ADDR_W + 1)'(1))) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (w_pipe_empty && ((r_count == '0) || ((r_count == CNT_W'(1)) && w_pop)))
          w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr   <= '0;
      r_remain <= '0;
      r_shift  <= '0;
`ifdef PE_DRAIN_RELU_EN
      r_relu   <= 1'b0;
`endif
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_shift <= shift;
`ifdef PE_DRAIN_RELU_EN
        r_relu  <= relu;
`endif
      end
      if (w_start_go) begin
        r_addr   <= f_addr_inc(base_addr);
        r_remain <= len - 1'b1;
      end else if (w_issue) begin
        r_addr   <= f_addr_inc(r_addr);
        r_remain <= r_remain - 1'b1;
      end
    end
  end

  always_comb begin
    w_q_data = '0;
    w_lane   = '0;
    for (int unsigned i = 0; i < BATCH; i++) begin
      w_lane = f_quant(abuf_rd_data[i*RES_W +: RES_W], r_shift);
`ifdef PE_DRAIN_RELU_EN
      if (r_relu && w_lane[DATA_W-1]) w_lane = '0;
`endif
      w_q_data[i*DATA_W +: DATA_W] = w_lane;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld    <= '0;
      r_q_vld  <= 1'b0;
      r_q_data <= '0;
    end else begin
      r_vld[0] <= w_issue;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
      r_q_vld  <= r_vld[RD_LAT-1];
      r_q_data <= w_q_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_q_data;
        r_wr_ptr        <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_pe_acc_drain.sv
// Scoreboard bench for pe_acc_drain: directed drains push expected words, a monitor pops
// and compares on every handshake and checks that stalled output words hold.
module tb_pe_acc_drain;
  localparam int unsigned BATCH      = 4;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned RES_W      = 32;
  localparam int unsigned BUF_DEPTH  = 256;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned ADDR_W     = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    start = 1'b0;
  logic [ADDR_W-1:0]       base_addr = '0;
  logic [ADDR_W:0]         len = '0;
  logic [4:0]              shift = '0;
  logic                    relu = 1'b0;
  logic                    busy, done;
  logic [ADDR_W-1:0]       abuf_rd_addr;
  logic [BATCH*RES_W-1:0]  abuf_rd_data;
  logic [BATCH*DATA_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready = 1'b1;

  pe_acc_drain #(
    .BATCH(BATCH), .DATA_W(DATA_W), .RES_W(RES_W), .BUF_DEPTH(BUF_DEPTH),
    .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .shift(shift), .relu(relu), .busy(busy), .done(done),
    .abuf_rd_addr(abuf_rd_addr), .abuf_rd_data(abuf_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Accumulation-buffer model with two-cycle read latency.
  logic [BATCH*RES_W-1:0] mem [BUF_DEPTH];
  logic [ADDR_W-1:0]      rd_s1 = '0;
  logic [BATCH*RES_W-1:0] rd_q = '0;
  always @(posedge clk) begin
    rd_s1 <= abuf_rd_addr;
    rd_q  <= mem[rd_s1];
  end
  assign abuf_rd_data = rd_q;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          first_valid_cyc = -1;
  int          first_pop_cyc = 0;
  int          last_pop_cyc = 0;
  int          n_pop = 0;
  logic        bp_mode = 1'b0;
  logic        stalled = 1'b0;
  logic [63:0] held = '0;
  logic [63:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = bp_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rep(input int unsigned v);
    logic [15:0] l;
    l = v[15:0];
    return {l, l, l, l};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", out_valid, 1);
        if (out_valid) check("hold_data", out_data, held);
      end
      if (out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: got %h expected none", out_data);
          end else begin
            check("word", out_data, exp_q.pop_front());
          end
          if (n_pop == 0) first_pop_cyc = cyc;
          last_pop_cyc = cyc;
          n_pop++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = out_data;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic pulse_start(input logic [7:0] b, input logic [8:0] l, input logic [4:0] s, input logic r);
    @(posedge clk);
    #1;
    base_addr = b; len = l; shift = s; relu = r; start = 1'b1;
    start_cyc = cyc; first_valid_cyc = -1; n_pop = 0;
    @(posedge clk);
    #1;
    start = 1'b0; base_addr = 8'h5A; len = 9'd3; shift = 5'd9; relu = ~r;
  endtask

  task automatic run_drain(input string tag, input logic [7:0] b, input logic [8:0] l,
                           input logic [4:0] s, input logic r);
    bit got;
    int dcyc;
    got  = 1'b0;
    dcyc = 0;
    pulse_start(b, l, s, r);
    for (int n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      if (n == 0) check({tag, "_busy"}, busy, 1);
      if (done) begin
        got  = 1'b1;
        dcyc = cyc;
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_done_timeout: got no done expected done within 3000 cycles", tag);
    end else if (l == 0) begin
      check({tag, "_done_cyc"}, dcyc, start_cyc + 1);
      check({tag, "_no_valid"}, first_valid_cyc, -1);
    end else begin
      check({tag, "_done_cyc"}, dcyc, last_pop_cyc + 1);
      check({tag, "_first_valid"}, first_valid_cyc, start_cyc + 4);
      check({tag, "_count"}, n_pop, l);
      if (!bp_mode) check({tag, "_throughput"}, last_pop_cyc - first_pop_cyc, l - 1);
    end
    @(negedge clk);
    check({tag, "_idle"}, {busy, done}, 0);
    check({tag, "_leftover"}, exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    bit ok;
    for (int a = 0; a < BUF_DEPTH; a++) mem[a] = {4{32'(a)}};
    mem[16]  = {32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFE8, 32'h00000018};
    mem[17]  = {32'hFFFFF000, 32'h00000007, 32'hFFFFFFF8, 32'h00000008};
    mem[18]  = {32'hFFF7FFF0, 32'hFFF80000, 32'h0007FFF7, 32'h00080000};
    mem[200] = {32'h00000000, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFB};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {busy, done, out_valid}, 0);
    check("rst_data", out_data, 0);
    check("rst_addr", abuf_rd_addr, 0);
    rst = 1'b1;

    for (int a = 0; a < 8; a++) exp_q.push_back(rep(a));
    run_drain("basic", 8'd0, 9'd8, 5'd0, 1'b0);

    exp_q.push_back({16'h8000, 16'h7FFF, 16'hFFFF, 16'h0002});
    exp_q.push_back({16'hFF00, 16'h0000, 16'h0000, 16'h0001});
    exp_q.push_back({16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF});
    run_drain("quant", 8'd16, 9'd3, 5'd4, 1'b0);

    bp_mode = 1'b1;
    for (int a = 32; a < 96; a++) exp_q.push_back(rep(a));
    run_drain("bp", 8'd32, 9'd64, 5'd0, 1'b0);
    bp_mode = 1'b0;

    exp_q.push_back(rep(254));
    exp_q.push_back(rep(255));
    exp_q.push_back(rep(0));
    exp_q.push_back(rep(1));
    run_drain("wrap", 8'd254, 9'd4, 5'd0, 1'b0);
    run_drain("len0", 8'd10, 9'd0, 5'd0, 1'b0);

`ifdef PE_DRAIN_RELU_EN
    exp_q.push_back({16'h0000, 16'h0000, 16'h0003, 16'h0000});
`else
    exp_q.push_back({16'h0000, 16'hFFFF, 16'h0003, 16'hFFFB});
`endif
    run_drain("relu1", 8'd200, 9'd1, 5'd0, 1'b1);
    exp_q.push_back({16'h0000, 16'hFFFF, 16'h0003, 16'hFFFB});
    run_drain("relu0", 8'd200, 9'd1, 5'd0, 1'b0);

    for (int a = 100; a < 132; a++) exp_q.push_back(rep(a));
    pulse_start(8'd100, 9'd32, 5'd0, 1'b0);
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (n_pop >= 10) ok = 1'b1;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL rstmid_wait: got %0d words expected 10 within 200 cycles", n_pop);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rstmid_ctrl", {busy, done, out_valid}, 0);
    check("rstmid_data", out_data, 0);
    check("rstmid_addr", abuf_rd_addr, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("rstmid_quiet", {busy, done, out_valid}, 0);
    end
    for (int a = 40; a < 46; a++) exp_q.push_back(rep(a));
    run_drain("after_rst", 8'd40, 9'd6, 5'd0, 1'b0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
